ysyx_23060203_regfile_sb: RTL

//  Next-generation integer register file for the pipelined core: parametrised width/depth,
//  two write-back ports (EXU, LSU), two read ports, and a per-register scoreboard of

---
 rtl/ysyx_23060203_regfile_sb_if.sv | 46 ++++
 rtl/ysyx_23060203_regfile_sb.sv | 119 +++++++++++
 2 files changed

// File: rtl/ysyx_23060203_regfile_sb_if.sv
// Bus bundle between decode/write-back and the scoreboarded register file.
// The master side (decode + write-back) drives issue, write and read-address
// signals; the slave side (the register file) returns read data, busy flags
// and issue acceptance.
interface ysyx_23060203_regfile_sb_if #(
  parameter int XLEN = 32
);

  logic            flush;
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic            iss_ready;

  logic            wen0;
  logic [4:0]      waddr0;
  logic [XLEN-1:0] wdata0;

  logic            wen1;
  logic [4:0]      waddr1;
  logic [XLEN-1:0] wdata1;

  logic [4:0]      raddr1;
  logic [XLEN-1:0] rdata1;
  logic            rbusy1;

  logic [4:0]      raddr2;
  logic [XLEN-1:0] rdata2;
  logic            rbusy2;

  modport master (
    output flush, iss_valid, iss_rd,
    output wen0, waddr0, wdata0,
    output wen1, waddr1, wdata1,
    output raddr1, raddr2,
    input  iss_ready, rdata1, rbusy1, rdata2, rbusy2
  );

  modport slave (
    input  flush, iss_valid, iss_rd,
    input  wen0, waddr0, wdata0,
    input  wen1, waddr1, wdata1,
    input  raddr1, raddr2,
    output iss_ready, rdata1, rbusy1, rdata2, rbusy2
  );

endinterface

// File: rtl/ysyx_23060203_regfile_sb.sv
// Integer register file with a per-register pending-write scoreboard.
// Two write-back ports (0 = EXU, 1 = LSU, port 1 wins on the same address),
// two combinational read ports, and a saturating counter per register that
// decode increments on issue and write-back decrements on retire.
// x0 and addresses >= NR_REG read as zero, are never busy and drop writes.
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data to
// the read ports and let the final retire clear busy in its own cycle.
module ysyx_23060203_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NR_REG = 16,
  parameter int CNT_W  = 2
) (
  input logic                      clk,
  input logic                      rstn,
  ysyx_23060203_regfile_sb_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]  rf      [NR_REG];
  logic [CNT_W-1:0] cnt     [NR_REG];
  logic [CNT_W-1:0] cnt_nxt [NR_REG];
  logic [1:0]       ret     [NR_REG];
  logic [NR_REG-1:0] hit0;
  logic [NR_REG-1:0] hit1;
  logic              ready;

  // Implemented, non-zero register address.
  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && (int'({27'd0, a}) < NR_REG);
  endfunction

  // Counter minus retires, floored at zero.
  function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] c,
                                                input logic [1:0]       n);
    if (32'(c) > 32'(n)) return CNT_W'(32'(c) - 32'(n));
    return '0;
  endfunction

  // Decode which register each write port hits and how many retires each register sees.
  always_comb begin
    for (int r = 0; r < NR_REG; r++) begin
      hit0[r] = bus.wen0 && addr_ok(bus.waddr0) && (bus.waddr0 == 5'(r));
      hit1[r] = bus.wen1 && addr_ok(bus.waddr1) && (bus.waddr1 == 5'(r));
      ret[r]  = {1'b0, hit0[r]} + {1'b0, hit1[r]};
    end
  end

  // Issue acceptance looks at the registered counter only; a same-cycle retire frees nothing.
  always_comb begin
    ready = 1'b1;
    for (int r = 1; r < NR_REG; r++) begin
      if (bus.iss_rd == 5'(r)) ready = (cnt[r] != CNT_MAX);
    end
  end

  assign bus.iss_ready = ready;

  // Next counter value: floor-limited retire first, then the accepted issue; flush clears all.
  always_comb begin
    for (int r = 0; r < NR_REG; r++) begin
      cnt_nxt[r] = sat_sub(cnt[r], ret[r]);
      if (bus.iss_valid && ready && addr_ok(bus.iss_rd) && (bus.iss_rd == 5'(r)))
        cnt_nxt[r] = cnt_nxt[r] + CNT_W'(1);
      if (bus.flush) cnt_nxt[r] = '0;
    end
  end

  // Read ports: zero for x0 and unimplemented addresses, optional same-cycle forwarding.
  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise an address
    // that matches no register would leave it unassigned and infer a latch.
    bus.rdata1 = '0;
    bus.rbusy1 = 1'b0;
    bus.rdata2 = '0;
    bus.rbusy2 = 1'b0;
    for (int r = 1; r < NR_REG; r++) begin
      if (bus.raddr1 == 5'(r)) begin
`ifdef RF_BYPASS_EN
        bus.rdata1 = hit1[r] ? bus.wdata1 : (hit0[r] ? bus.wdata0 : rf[r]);
        bus.rbusy1 = (sat_sub(cnt[r], ret[r]) != '0);
`else
        bus.rdata1 = rf[r];
        bus.rbusy1 = (cnt[r] != '0);
`endif
      end
      if (bus.raddr2 == 5'(r)) begin
`ifdef RF_BYPASS_EN
        bus.rdata2 = hit1[r] ? bus.wdata1 : (hit0[r] ? bus.wdata0 : rf[r]);
        bus.rbusy2 = (sat_sub(cnt[r], ret[r]) != '0);
`else
        bus.rdata2 = rf[r];
        bus.rbusy2 = (cnt[r] != '0);
`endif
      end
    end
  end

  // Register array and scoreboard state; synchronous active-low reset clears both.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: the data array is reset on purpose - software may rely on every
      // register reading zero after reset, so this cannot map onto a plain RAM.
      for (int r = 0; r < NR_REG; r++) begin
        rf[r]  <= '0;
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NR_REG; r++) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge state, independent of statement order inside this block.
        cnt[r] <= cnt_nxt[r];
        if (hit1[r])      rf[r] <= bus.wdata1;
        else if (hit0[r]) rf[r] <= bus.wdata0;
      end
    end
  end

endmodule
